adder_acc_64: RTL
=================

Name: adder_acc_64

Overview:
- Streaming 64-bit accumulator that sits directly downstream of adder_64 and consumes its sum and cout.
- Instantiates one adder_64 with in1 = accumulator register, in2 = incoming operand, cin = 0.
- Registers the sum back into the accumulator, counts carries and operands, and presents the frame total on a valid/ready output once the operand flagged last has been absorbed.

Parameters:
- CNT_W, 16, width of the operand counter and the carry counter (range 2..32).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  64  operand
- in_last  input  1  operand is the final one of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  64  accumulated sum, modulo 2^64
- out_carries  output  CNT_W  number of adder_64 cout=1 events in the frame
- out_count  output  CNT_W  number of operands in the frame

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = ACC
  - acc = 0, carry_cnt = 0, op_cnt = 0
  - out_valid = 0, out_sum = 0, out_carries = 0, out_count = 0
  - in_ready = 1 once rst deasserts
- Reset mid-frame discards the partial frame. A pending result not yet accepted is dropped.
- Input accept rule: an operand is taken on a rising edge when in_valid && in_ready.
- State ACC (in_ready = 1). On each accepted operand:
  - acc <= adder_64.sum (acc + in_data)
  - carry_cnt <= carry_cnt + cout
  - op_cnt <= op_cnt + 1
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - If in_last = 1 on the accepted beat:
    - out_sum <= new sum
    - out_carries <= new carry_cnt
    - out_count <= new op_cnt
    - out_valid <= 1
    - acc, carry_cnt and op_cnt clear to 0 on the same edge
    - state -> HOLD
- State HOLD (in_ready = 0):
  - Outputs stay stable while out_valid && !out_ready.
  - On the edge where out_ready = 1: out_valid <= 0, state -> ACC. in_ready returns to 1 in the following cycle; there is no same-cycle bypass.
- Latency: the result is visible one clock after the last operand is accepted.
- Single-operand frame (in_last on the first beat): out_sum = in_data, out_count = 1.
- in_valid = 0 in ACC: no change in any register.
- in_data and in_last are don't-care when in_valid = 0.
- Carry detection uses adder_64.cout only. Sum arithmetic is always modulo 2^64.
- out_sum, out_carries and out_count hold their last values after handshake completes, until the next frame result is written.

Optional Feature:
- Macro ADDER_ACC_64_SAT_EN.
- Defined:
  - When an accepted operand produces cout = 1, acc (and out_sum if last) is forced to 64'hFFFF_FFFF_FFFF_FFFF.
  - It remains saturated for the rest of the frame. Later adds are still counted but do not change acc.
  - out_carries still counts every cout event, including adds made while saturated that would have carried.
- Not defined: plain modulo-2^64 wrap as described above. No extra ports either way.

Test Plan:
- Reset then frame {5, 7, 9 (last)}, out_ready = 1 -> out_valid one cycle after the third accept, out_sum = 21, out_count = 3, out_carries = 0, in_ready low for exactly one cycle.
- Frame {64'hFFFF_FFFF_FFFF_FFFF, 2 (last)}:
  - Without SAT_EN: out_sum = 1, out_carries = 1.
  - With ADDER_ACC_64_SAT_EN: out_sum = all ones, out_carries = 1.
- Single-operand frame {64'h1234 (last)} with out_ready held 0 for 5 cycles -> out_valid and out_sum = 64'h1234 stable, in_ready = 0 throughout; accepted on the cycle out_ready rises.
- Frame of 4 operands with in_valid toggled 1,0,0,1,1,0,1 -> only valid beats accumulate; out_count = 4, out_sum = exact sum.
- Assert rst asynchronously (between edges) after 2 of 3 operands -> all outputs 0 immediately. Next frame {10 (last)} -> out_sum = 10, out_count = 1.
- Two back-to-back frames {1, 2 (last)}, {3 (last)} -> results 3 then 3, with out_count values 2 then 1, and no state leakage between frames.

Source files
------------

// File: rtl/adder_acc_64.sv
// Streaming 64-bit accumulator built around adder_64, with frame result on valid/ready.
// Optional macro ADDER_ACC_64_SAT_EN: saturate the running sum at all ones after the first carry of a frame.

module adder_64 (
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, in1} + {1'b0, in2} + {64'd0, cin};
endmodule

module adder_acc_64 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [63:0]       acc;
  logic [CNT_W-1:0]  carry_cnt, op_cnt;
  logic [63:0]       sum_w;
  logic              cout_w;
  logic              accept;
  logic [63:0]       acc_nxt;
  logic [CNT_W-1:0]  carry_nxt, op_nxt;

  adder_64 u_adder (
    .in1  (acc),
    .in2  (in_data),
    .cin  (1'b0),
    .sum  (sum_w),
    .cout (cout_w)
  );

  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready;

  // Counters stick at all ones rather than wrapping
  assign carry_nxt = (carry_cnt == CNT_MAX || !cout_w) ? carry_cnt : carry_cnt + CNT_ONE;
  assign op_nxt    = (op_cnt == CNT_MAX) ? op_cnt : op_cnt + CNT_ONE;

`ifdef ADDER_ACC_64_SAT_EN
  logic sat;
  assign acc_nxt = (sat || cout_w) ? 64'hFFFF_FFFF_FFFF_FFFF : sum_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (accept) begin
      sat <= in_last ? 1'b0 : (sat || cout_w);
    end
  end
`else
  assign acc_nxt = sum_w;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (accept && in_last) state_nxt = HOLD;
      HOLD: if (out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      acc         <= 64'd0;
      carry_cnt   <= '0;
      op_cnt      <= '0;
      out_valid   <= 1'b0;
      out_sum     <= 64'd0;
      out_carries <= '0;
      out_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (in_last) begin
          acc         <= 64'd0;
          carry_cnt   <= '0;
          op_cnt      <= '0;
          out_sum     <= acc_nxt;
          out_carries <= carry_nxt;
          out_count   <= op_nxt;
          out_valid   <= 1'b1;
        end else begin
          acc       <= acc_nxt;
          carry_cnt <= carry_nxt;
          op_cnt    <= op_nxt;
        end
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
